// File: rtl/mdio_read_seq.sv
// mdio_read_seq: sweeps a rectangular (memory index x address) window over the
// MDIO register-file read port. It issues one read pulse per word, captures the
// returned data two cycles later and hands each word to the host through a
// rd_valid/rd_ack hold register before moving to the next word.
//
// Host handshake: rd_valid=1 means rd_data holds an unconsumed word. A word
// transfers on a rising edge where rd_valid=1 and rd_ack=1. rd_data is stable
// while rd_valid=1, and rd_ack is ignored while rd_valid=0. seq_abort wins over
// rd_ack in the same cycle, so an aborted word is dropped and not counted.
module mdio_read_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        seq_start,
  input  logic        seq_abort,
  input  logic [6:0]  cfg_sel_first,
  input  logic [6:0]  cfg_sel_last,
  input  logic [14:0] cfg_addr_last,
  output logic        mdio_rd_en,
  output logic        rf_mdio_read_en,
  output logic [6:0]  rf_mdio_which_memory_sel,
  output logic [14:0] rf_mdio_memory_addr,
  input  logic [8:0]  rf_mdio_pkt_data,
  output logic [8:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ack,
  output logic [21:0] rd_cnt,
  output logic        seq_busy,
  output logic        seq_done,
  output logic        seq_err,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT1 = 3'd2;
  localparam logic [2:0] ST_CAPT  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;

  // Highest memory index the register file decodes.
  localparam logic [6:0]  SEL_MAX = 7'd95;
  localparam logic [21:0] CNT_MAX = 22'h3F_FFFF;

  logic [2:0]  state;
  logic [6:0]  sel_last_q;
  logic [14:0] addr_last_q;
  logic        cfg_ok;

  // The window bounds are latched at start so host writes mid-sweep cannot
  // move the end point.
  assign cfg_ok    = (cfg_sel_first <= cfg_sel_last) && (cfg_sel_last <= SEL_MAX);
  assign dbg_state = state;

  // Sequencer state and every output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                    <= ST_IDLE;
      sel_last_q               <= 7'd0;
      addr_last_q              <= 15'd0;
      mdio_rd_en               <= 1'b0;
      rf_mdio_read_en          <= 1'b0;
      rf_mdio_which_memory_sel <= 7'd0;
      rf_mdio_memory_addr      <= 15'd0;
      rd_data                  <= 9'd0;
      rd_valid                 <= 1'b0;
      rd_cnt                   <= 22'd0;
      seq_busy                 <= 1'b0;
      seq_done                 <= 1'b0;
      seq_err                  <= 1'b0;
    end else begin
      // The read pulse is only ever raised for the single cycle spent in ISSUE.
      rf_mdio_read_en <= 1'b0;
      if ((state != ST_IDLE) && seq_abort) begin
        state      <= ST_IDLE;
        rd_valid   <= 1'b0;
        seq_busy   <= 1'b0;
        mdio_rd_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (seq_start && !seq_abort) begin
              if (cfg_ok) begin
                sel_last_q               <= cfg_sel_last;
                addr_last_q              <= cfg_addr_last;
                rf_mdio_which_memory_sel <= cfg_sel_first;
                rf_mdio_memory_addr      <= 15'd0;
                rd_cnt                   <= 22'd0;
                seq_done                 <= 1'b0;
                seq_err                  <= 1'b0;
                seq_busy                 <= 1'b1;
                mdio_rd_en               <= 1'b1;
                rf_mdio_read_en          <= 1'b1;
                state                    <= ST_ISSUE;
              end else begin
                seq_err <= 1'b1;
              end
            end
          end
          ST_ISSUE: state <= ST_WAIT1;
          ST_WAIT1: state <= ST_CAPT;
          ST_CAPT: begin
            rd_data  <= rf_mdio_pkt_data;
            rd_valid <= 1'b1;
            state    <= ST_HOLD;
          end
          ST_HOLD: begin
            if (rd_ack) begin
              rd_valid <= 1'b0;
              if (rd_cnt != CNT_MAX) begin
                rd_cnt <= rd_cnt + 22'd1;
              end
              state <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (rf_mdio_memory_addr < addr_last_q) begin
              rf_mdio_memory_addr <= rf_mdio_memory_addr + 15'd1;
              rf_mdio_read_en     <= 1'b1;
              state               <= ST_ISSUE;
            end else if (rf_mdio_which_memory_sel < sel_last_q) begin
              rf_mdio_which_memory_sel <= rf_mdio_which_memory_sel + 7'd1;
              rf_mdio_memory_addr      <= 15'd0;
              rf_mdio_read_en          <= 1'b1;
              state                    <= ST_ISSUE;
            end else begin
              seq_done   <= 1'b1;
              seq_busy   <= 1'b0;
              mdio_rd_en <= 1'b0;
              state      <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_read_seq.sv
// Bench for mdio_read_seq: table-driven sweeps with a word scoreboard, plus
// hand-written abort, priority and reset sequences.
module tb_mdio_read_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        seq_start, seq_abort, rd_ack;
  logic [6:0]  cfg_sel_first, cfg_sel_last;
  logic [14:0] cfg_addr_last;
  logic        mdio_rd_en, rf_mdio_read_en, rd_valid, seq_busy, seq_done, seq_err;
  logic [6:0]  rf_mdio_which_memory_sel;
  logic [14:0] rf_mdio_memory_addr;
  logic [8:0]  rf_mdio_pkt_data, rd_data;
  logic [21:0] rd_cnt;
  logic [2:0]  dbg_state;

  mdio_read_seq dut (
    .clk(clk), .rst(rst), .seq_start(seq_start), .seq_abort(seq_abort),
    .cfg_sel_first(cfg_sel_first), .cfg_sel_last(cfg_sel_last), .cfg_addr_last(cfg_addr_last),
    .mdio_rd_en(mdio_rd_en), .rf_mdio_read_en(rf_mdio_read_en),
    .rf_mdio_which_memory_sel(rf_mdio_which_memory_sel), .rf_mdio_memory_addr(rf_mdio_memory_addr),
    .rf_mdio_pkt_data(rf_mdio_pkt_data), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ack(rd_ack),
    .rd_cnt(rd_cnt), .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err),
    .dbg_state(dbg_state)
  );

  // Clock / read-stage stub: returned data is the address plus 0x100.
  always #5 clk = ~clk;
  assign rf_mdio_pkt_data = 9'(rf_mdio_memory_addr + 15'h100);

  typedef struct {
    logic [6:0]  sf;
    logic [6:0]  sl;
    logic [14:0] al;
    int          hold1;     // cycles rd_valid stays high on the first word
    int          hold_max;  // random hold bound for later words
    bit          tie;       // rd_ack tied high for the whole sweep
    bit          exp_err;
    int          exp_words;
  } vec_t;

  vec_t        vecs[8];
  int          total = 0;
  int          bad = 0;
  logic [30:0] exp_q[$];   // {sel, addr, data} per expected word
  int          hold_q[$];
  int          pulses, valid_cycles, hold_target;
  logic [8:0]  held_data;
  bit          tie_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Per-cycle monitor and host driver, called at each negedge during a sweep.
  task automatic service();
    if (rf_mdio_read_en) begin
      pulses++;
      chk("pulse_while_valid", {31'd0, rd_valid}, 32'd0);
    end
    if (rd_valid) begin
      if (valid_cycles == 0) begin
        hold_target = (hold_q.size() > 0) ? hold_q.pop_front() : 1;
        held_data   = rd_data;
      end else begin
        chk("hold_data_stable", {23'd0, rd_data}, {23'd0, held_data});
      end
      valid_cycles++;
      if (valid_cycles >= hold_target) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got sel=%0d addr=%0h data=%0h, want no word",
                   rf_mdio_which_memory_sel, rf_mdio_memory_addr, rd_data);
        end else begin
          logic [30:0] e;
          e = exp_q.pop_front();
          chk("word_sel_addr_data", {1'b0, rf_mdio_which_memory_sel, rf_mdio_memory_addr, rd_data}, {1'b0, e});
        end
        rd_ack       = 1'b1;
        valid_cycles = 0;
      end else begin
        rd_ack = tie_ack;
      end
    end else begin
      rd_ack = tie_ack;
    end
  endtask

  task automatic run_sweep(input vec_t v);
    int  exp_cycles, cyc, h;
    bit  first;
    exp_cycles = 0;
    first      = 1'b1;
    if (!v.exp_err) begin
      for (int s = int'(v.sf); s <= int'(v.sl); s++) begin
        for (int a = 0; a <= int'(v.al); a++) begin
          if (v.tie)      h = 1;
          else if (first) h = v.hold1;
          else            h = $urandom_range(1, v.hold_max);
          first = 1'b0;
          exp_q.push_back({7'(s), 15'(a), 9'(a + 256)});
          hold_q.push_back(h);
          exp_cycles += 4 + h;
        end
      end
    end
    tie_ack       = v.tie;
    rd_ack        = v.tie;
    pulses        = 0;
    valid_cycles  = 0;
    cfg_sel_first = v.sf;
    cfg_sel_last  = v.sl;
    cfg_addr_last = v.al;
    seq_start     = 1'b1;
    step();
    seq_start     = 1'b0;
    // Configuration changes after start must not affect the running sweep.
    cfg_sel_first = 7'($urandom_range(0, 127));
    cfg_sel_last  = 7'($urandom_range(0, 127));
    cfg_addr_last = 15'($urandom_range(0, 32767));
    if (v.exp_err) begin
      repeat (4) begin
        service();
        step();
      end
      chk("err_set", {31'd0, seq_err}, 32'd1);
      chk("err_not_busy", {31'd0, seq_busy}, 32'd0);
      chk("err_no_pulse", pulses, 0);
      chk("err_state_idle", {29'd0, dbg_state}, 32'd0);
    end else begin
      chk("start_err_cleared", {31'd0, seq_err}, 32'd0);
      chk("start_done_cleared", {31'd0, seq_done}, 32'd0);
      chk("start_rd_en", {31'd0, mdio_rd_en}, 32'd1);
      cyc = 0;
      while (seq_busy && cyc < 2000) begin
        service();
        seq_start = (cyc == 2);  // a start while busy must be ignored
        step();
        cyc++;
      end
      seq_start = 1'b0;
      if (seq_busy) begin
        total++;
        bad++;
        $display("FAIL sweep_timeout: got busy after %0d cycles, want idle", cyc);
      end
      chk("sweep_cycles", cyc, exp_cycles);
      chk("sweep_pulses", pulses, v.exp_words);
      chk("sweep_rd_cnt", {10'd0, rd_cnt}, v.exp_words);
      chk("sweep_done", {31'd0, seq_done}, 32'd1);
      chk("sweep_rd_en_off", {31'd0, mdio_rd_en}, 32'd0);
      chk("sweep_valid_off", {31'd0, rd_valid}, 32'd0);
      chk("sweep_sb_empty", exp_q.size(), 0);
    end
    tie_ack = 1'b0;
    rd_ack  = 1'b0;
    exp_q.delete();
    hold_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, {31'd0, mdio_rd_en}, 32'd0);
    chk({tag, "_read_pulse"}, {31'd0, rf_mdio_read_en}, 32'd0);
    chk({tag, "_sel"}, {25'd0, rf_mdio_which_memory_sel}, 32'd0);
    chk({tag, "_addr"}, {17'd0, rf_mdio_memory_addr}, 32'd0);
    chk({tag, "_rd_data"}, {23'd0, rd_data}, 32'd0);
    chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    chk({tag, "_rd_cnt"}, {10'd0, rd_cnt}, 32'd0);
    chk({tag, "_flags"}, {29'd0, seq_busy, seq_done, seq_err}, 32'd0);
    chk({tag, "_state"}, {29'd0, dbg_state}, 32'd0);
  endtask

  // Safety net against a hung DUT handshake.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Clock / reset block.
    rst = 1'b1; seq_start = 1'b0; seq_abort = 1'b0; rd_ack = 1'b0; tie_ack = 1'b0;
    cfg_sel_first = 7'd0; cfg_sel_last = 7'd0; cfg_addr_last = 15'd0;
    valid_cycles = 0; pulses = 0; hold_target = 1; held_data = 9'd0;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Table: sf, sl, al, hold1, hold_max, tie, exp_err, exp_words.
    vecs[0] = '{7'd3,  7'd3,  15'd1,  1, 1, 1'b1, 1'b0, 2};
    vecs[1] = '{7'd94, 7'd95, 15'd0,  1, 1, 1'b0, 1'b0, 2};
    vecs[2] = '{7'd0,  7'd1,  15'd2,  7, 1, 1'b0, 1'b0, 6};
    vecs[3] = '{7'd10, 7'd5,  15'd0,  1, 1, 1'b0, 1'b1, 0};
    vecs[4] = '{7'd20, 7'd22, 15'd3,  2, 4, 1'b0, 1'b0, 12};
    vecs[5] = '{7'd5,  7'd96, 15'd0,  1, 1, 1'b0, 1'b1, 0};
    vecs[6] = '{7'd95, 7'd95, 15'd0,  3, 1, 1'b0, 1'b0, 1};
    vecs[7] = '{7'd0,  7'd0,  15'd40, 1, 2, 1'b0, 1'b0, 41};
    for (int i = 0; i < 8; i++) begin
      run_sweep(vecs[i]);
      step();
    end

    // Abort in WAIT1 of the third word, rd_ack tied high.
    exp_q.push_back({7'd7, 15'd0, 9'h100});
    exp_q.push_back({7'd7, 15'd1, 9'h101});
    hold_q.push_back(1);
    hold_q.push_back(1);
    tie_ack = 1'b1; rd_ack = 1'b1; pulses = 0; valid_cycles = 0;
    cfg_sel_first = 7'd7; cfg_sel_last = 7'd7; cfg_addr_last = 15'd4;
    seq_start = 1'b1;
    step();
    seq_start = 1'b0;
    cyc = 0;
    while (pulses < 3 && cyc < 100) begin
      service();
      step();
      cyc++;
    end
    chk("abort_at_wait1", {29'd0, dbg_state}, 32'd2);
    seq_abort = 1'b1;
    step();
    seq_abort = 1'b0;
    chk("abort_state_idle", {29'd0, dbg_state}, 32'd0);
    chk("abort_valid", {31'd0, rd_valid}, 32'd0);
    chk("abort_rd_en", {31'd0, mdio_rd_en}, 32'd0);
    chk("abort_busy", {31'd0, seq_busy}, 32'd0);
    chk("abort_rd_cnt", {10'd0, rd_cnt}, 32'd2);
    chk("abort_done", {31'd0, seq_done}, 32'd0);
    chk("abort_sb_empty", exp_q.size(), 0);
    tie_ack = 1'b0; rd_ack = 1'b0;
    repeat (5) begin
      service();
      step();
    end
    chk("abort_no_more_pulses", pulses, 3);

    // Start together with abort in IDLE is ignored.
    cfg_sel_first = 7'd1; cfg_sel_last = 7'd1; cfg_addr_last = 15'd0;
    seq_start = 1'b1; seq_abort = 1'b1;
    step();
    seq_start = 1'b0; seq_abort = 1'b0;
    chk("start_abort_idle_busy", {31'd0, seq_busy}, 32'd0);
    chk("start_abort_idle_cnt", {10'd0, rd_cnt}, 32'd2);

    // Abort beats rd_ack in HOLD: the word is dropped and not counted.
    cfg_sel_first = 7'd2; cfg_sel_last = 7'd2; cfg_addr_last = 15'd3;
    seq_start = 1'b1;
    step();
    seq_start = 1'b0;
    cyc = 0;
    while (!rd_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk("prio_reached_hold", {29'd0, dbg_state}, 32'd4);
    rd_ack = 1'b1; seq_abort = 1'b1;
    step();
    rd_ack = 1'b0; seq_abort = 1'b0;
    chk("prio_rd_cnt", {10'd0, rd_cnt}, 32'd0);
    chk("prio_state_idle", {29'd0, dbg_state}, 32'd0);
    chk("prio_valid", {31'd0, rd_valid}, 32'd0);

    // Reset while holding the second word, then restart.
    cfg_sel_first = 7'd12; cfg_sel_last = 7'd13; cfg_addr_last = 15'd2;
    seq_start = 1'b1;
    step();
    seq_start = 1'b0;
    cyc = 0;
    while (!(rd_valid && rd_cnt == 22'd1) && cyc < 50) begin
      rd_ack = (rd_cnt == 22'd0);
      step();
      cyc++;
    end
    rd_ack = 1'b0;
    chk("rst_pre_hold_data", {23'd0, rd_data}, 32'h101);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    step();
    rst = 1'b0;
    pulses = 0; valid_cycles = 0;
    repeat (4) begin
      service();
      step();
    end
    chk("rst_no_pulse", pulses, 0);
    chk("rst_stays_idle", {31'd0, seq_busy}, 32'd0);
    run_sweep('{7'd12, 7'd12, 15'd1, 2, 3, 1'b0, 1'b0, 2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
